cfa_frame_writer: RTL and testbench

- Output-side producer for the CFA convolution datapath. Takes convolved result pixels on a valid/ready input and buffers them in a small FIFO. Emits them as one ordered, addressed frame stream with row/column tags and end-of-frame marking.
- Feeds the output-image dump and the hardware golden-check path. Produces exactly the raster-ordered, one-word-per-pixel sequence those consumers read back.

---
 rtl/cfa_frame_writer.sv | 144 ++++++++++++++
 tb/tb_cfa_frame_writer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cfa_frame_writer.sv
// CFA output frame writer: buffers convolved pixels in a small FIFO and
// emits them as one raster-ordered, addressed frame with row/col tags.
module cfa_frame_writer #(
    parameter int DATA_W     = 20,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic [ADDR_W-1:0] out_row,
    output logic [ADDR_W-1:0] out_col,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam int TOTAL_I = IMG_W * IMG_H;
    localparam int PW      = $clog2(FIFO_DEPTH);

    // in_cnt carries one extra bit so it can hold TOTAL itself
    localparam logic [ADDR_W:0]   TOTAL    = (ADDR_W+1)'(TOTAL_I);
    localparam logic [ADDR_W:0]   IN_LAST  = (ADDR_W+1)'(TOTAL_I - 1);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(TOTAL_I - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [PW:0]       DEPTH    = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;
    logic   clr;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [PW:0]       count;

    logic [ADDR_W:0]   in_cnt;
    logic [ADDR_W-1:0] out_cnt, row, col;

    logic push, pop;

    assign in_ready  = (state == S_RUN) && (in_cnt < TOTAL) && (count < DEPTH);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data = out_valid ? mem[rd_ptr] : '0;
    assign out_addr = out_cnt;
    assign out_row  = row;
    assign out_col  = col;
    assign out_last = out_valid && (out_cnt == OUT_LAST);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                    clr       = 1'b1;
                end
            end
            S_RUN: begin
                if (push && (in_cnt == IN_LAST)) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && (out_cnt == OUT_LAST)) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                clr       = 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Storage needs no reset: out_data is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
        end else if (clr) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            if (push) in_cnt <= in_cnt + 1'b1;
            if (pop) begin
                out_cnt <= out_cnt + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfa_frame_writer.sv
// Randomised frame-level bench for cfa_frame_writer with a
// queue-free occupancy/sequence reference model.
module tb_cfa_frame_writer;

    localparam int DATA_W = 20;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int TOTAL  = IMG_W * IMG_H;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr, out_row, out_col;
    logic              out_last, busy, done;

    cfa_frame_writer #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .FIFO_DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int sent, recv, dones, lasts;
    bit running;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic outputs_zero(input string pfx);
        check({pfx, "_in_ready"},  32'(in_ready),  0);
        check({pfx, "_out_valid"}, 32'(out_valid), 0);
        check({pfx, "_out_data"},  32'(out_data),  0);
        check({pfx, "_out_addr"},  32'(out_addr),  0);
        check({pfx, "_out_row"},   32'(out_row),   0);
        check({pfx, "_out_col"},   32'(out_col),   0);
        check({pfx, "_out_last"},  32'(out_last),  0);
        check({pfx, "_busy"},      32'(busy),      0);
        check({pfx, "_done"},      32'(done),      0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start     = 1'b0;
            in_valid  = 1'b1;
            in_data   = DATA_W'(TOTAL);
            out_ready = 1'b1;
            #1;
            check("idle_in_ready",  32'(in_ready),  0);
            check("idle_out_valid", 32'(out_valid), 0);
            check("idle_busy",      32'(busy),      0);
            check("idle_done",      32'(done),      0);
        end
        in_valid = 1'b0;
    endtask

    // Pixel k of a frame carries data k at linear address k.
    task automatic frame(input int iv_pct, input int or_pct,
                         input int stall, input int abort_at);
        int  cyc = 0;
        int  occ;
        bit  fin = 0;
        bit  infire, outfire, dn;
        sent = 0; recv = 0; dones = 0; lasts = 0; running = 0;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            start     = (cyc == 0);
            in_valid  = ($urandom_range(99) < iv_pct);
            in_data   = DATA_W'(sent);
            out_ready = (cyc >= stall) && ($urandom_range(99) < or_pct);
            if (abort_at >= 0 && recv == abort_at && running) begin
                rst_n = 1'b0;
                #1;
                outputs_zero("abort");
                @(negedge clk);
                rst_n    = 1'b1;
                start    = 1'b0;
                in_valid = 1'b0;
                running  = 0;
                return;
            end
            #1;
            occ = sent - recv;
            check("out_valid", 32'(out_valid), 32'(occ > 0));
            check("in_ready", 32'(in_ready),
                  32'(running && sent < TOTAL && occ < DEPTH));
            check("busy", 32'(busy), 32'(running));
            if (out_valid) begin
                check("out_data", 32'(out_data), recv);
                check("out_addr", 32'(out_addr), recv);
                check("out_row",  32'(out_row),  recv / IMG_W);
                check("out_col",  32'(out_col),  recv % IMG_W);
                check("out_last", 32'(out_last), 32'(recv == TOTAL - 1));
            end
            if (stall > 0 && cyc == stall) begin
                check("bp_accepts", sent, DEPTH);
                check("bp_hold_data", 32'(out_data), 0);
            end
            dn = done;
            if (done) begin
                dones++;
                check("done_fifo_empty", occ, 0);
                check("done_after_all", recv, TOTAL);
            end
            infire  = in_valid && in_ready;
            outfire = out_valid && out_ready;
            if (outfire && out_last) lasts++;
            @(posedge clk);
            if (start)   running = 1;
            if (infire)  sent++;
            if (outfire) recv++;
            if (dn) begin
                running = 0;
                fin     = 1;
            end
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("frame_done_pulses", dones, 1);
        check("frame_last_count",  lasts, 1);
        check("frame_pixels",      recv,  TOTAL);
    endtask

    initial begin
        #1;
        outputs_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        idle(20);

        frame(100, 100, 0, -1);
        frame(100, 100, 10, -1);
        idle(3);

        for (int s = 0; s < 3; s++) begin
            void'($urandom(32'(17 + 101 * s)));
            frame(60, 50, 0, -1);
        end

        frame(70, 70, 0, 30);
        frame(100, 100, 0, -1);

        frame(100, 100, 0, -1);
        idle(5);
        frame(100, 100, 0, -1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
